vx_mem_perf_monitor: RTL

- Parametrised memory-traffic performance monitor for the core.
- Counts per-lane read and write request fires and response fires across NUM_CHANNELS memory channels of NUM_LANES lanes each.
- Tracks outstanding reads, accumulates load latency (sum of outstanding reads per cycle) and records peak outstanding.
- Adds gating, clear, saturation and error flags. Instantiated once per memory path (dcache, icache with NUM_LANES=1, lmem); outputs feed the pipeline perf interface.

---
 rtl/vx_mem_perf_monitor.sv | 120 ++++++++++++
 1 files changed

// File: rtl/vx_mem_perf_monitor.sv
// Memory-traffic performance monitor: counts read/write lane requests, tracks
// outstanding reads and accumulates load latency, peak and error flags.
module vx_mem_perf_monitor #(
  parameter int NUM_CHANNELS = 1,
  parameter int NUM_LANES    = 4,
  parameter int CTR_W        = 44,
  parameter int PEND_W       = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              clear,
  input  logic [NUM_CHANNELS*NUM_LANES-1:0] req_fire,
  input  logic [NUM_CHANNELS-1:0]           req_rw,
  input  logic [NUM_CHANNELS*NUM_LANES-1:0] rsp_fire,
  output logic [CTR_W-1:0]                  reads,
  output logic [CTR_W-1:0]                  writes,
  output logic [PEND_W-1:0]                 pending,
  output logic [CTR_W-1:0]                  latency,
  output logic [PEND_W-1:0]                 peak_pending,
  output logic                              ovf,
  output logic                              underflow
);

  localparam int TOTAL = NUM_CHANNELS * NUM_LANES;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int SW    = ((PEND_W > CNT_W) ? PEND_W : CNT_W) + 2;

  logic [TOTAL-1:0] rd_mask;
  logic [TOTAL-1:0] wr_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      assign rd_mask[gi*NUM_LANES +: NUM_LANES] = req_fire[gi*NUM_LANES +: NUM_LANES] & {NUM_LANES{~req_rw[gi]}};
      assign wr_mask[gi*NUM_LANES +: NUM_LANES] = req_fire[gi*NUM_LANES +: NUM_LANES] & {NUM_LANES{req_rw[gi]}};
    end
  endgenerate

  logic [CNT_W-1:0] rd_cnt, wr_cnt, rsp_cnt;

  always_comb begin
    rd_cnt  = '0;
    wr_cnt  = '0;
    rsp_cnt = '0;
    for (int i = 0; i < TOTAL; i++) begin
      rd_cnt  = rd_cnt  + CNT_W'(rd_mask[i]);
      wr_cnt  = wr_cnt  + CNT_W'(wr_mask[i]);
      rsp_cnt = rsp_cnt + CNT_W'(rsp_fire[i]);
    end
  end

  logic [CNT_W-1:0] rd_r, wr_r, rsp_r;

  // Pending update in signed arithmetic wide enough to see both clamp cases
  logic signed [SW-1:0] pend_sum;
  logic                 pend_neg, pend_big;
  logic [PEND_W-1:0]    pending_next;

  always_comb begin
    pend_sum     = signed'(SW'(pending)) + signed'(SW'(rd_r)) - signed'(SW'(rsp_r));
    pend_neg     = pend_sum[SW-1];
    pend_big     = !pend_neg && (pend_sum > signed'(SW'({PEND_W{1'b1}})));
    pending_next = pend_neg ? '0 : (pend_big ? {PEND_W{1'b1}} : pend_sum[PEND_W-1:0]);
  end

  logic [CTR_W:0]    reads_sum, writes_sum, latency_sum;
  logic [CTR_W-1:0]  reads_next, writes_next, latency_next;
  logic [PEND_W-1:0] peak_next;
  logic              stat_sat;

  always_comb begin
    reads_sum    = {1'b0, reads}   + (CTR_W+1)'(rd_r);
    writes_sum   = {1'b0, writes}  + (CTR_W+1)'(wr_r);
    latency_sum  = {1'b0, latency} + (CTR_W+1)'(pending);
    reads_next   = reads_sum[CTR_W]   ? {CTR_W{1'b1}} : reads_sum[CTR_W-1:0];
    writes_next  = writes_sum[CTR_W]  ? {CTR_W{1'b1}} : writes_sum[CTR_W-1:0];
    latency_next = latency_sum[CTR_W] ? {CTR_W{1'b1}} : latency_sum[CTR_W-1:0];
    peak_next    = (pending_next > peak_pending) ? pending_next : peak_pending;
    stat_sat     = reads_sum[CTR_W] | writes_sum[CTR_W] | latency_sum[CTR_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_r         <= '0;
      wr_r         <= '0;
      rsp_r        <= '0;
      pending      <= '0;
      reads        <= '0;
      writes       <= '0;
      latency      <= '0;
      peak_pending <= '0;
      ovf          <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      rd_r    <= rd_cnt;
      wr_r    <= wr_cnt;
      rsp_r   <= rsp_cnt;
      pending <= pending_next;
      if (clear) begin
        reads        <= '0;
        writes       <= '0;
        latency      <= '0;
        peak_pending <= '0;
        ovf          <= 1'b0;
        underflow    <= 1'b0;
      end else begin
        if (enable) begin
          reads        <= reads_next;
          writes       <= writes_next;
          latency      <= latency_next;
          peak_pending <= peak_next;
        end
        if (pend_neg) underflow <= 1'b1;
        if (pend_big || (enable && stat_sat)) ovf <= 1'b1;
      end
    end
  end

endmodule
